// File: rtl/alu_pkg.sv
// alu_pkg: function codes, flag bit positions and handshake FSM states for alu_mc
package alu_pkg;
  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_XOR = 4'b0100;
  localparam logic [3:0] F_CMP = 4'b0101;
  localparam logic [3:0] F_ADC = 4'b0110;
  localparam logic [3:0] F_SBC = 4'b0111;
  localparam logic [3:0] F_MOV = 4'b1000;
  localparam logic [3:0] F_SHL = 4'b1001;
  localparam logic [3:0] F_SHR = 4'b1010;
  localparam logic [3:0] F_SAR = 4'b1011;
  localparam logic [3:0] F_MUL = 4'b1100;
  localparam logic [3:0] F_NOP = 4'b1101;
  localparam int FS = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  typedef enum logic {IDLE, ITER} state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle shifter and shift-add multiplier; done when the count drains
module alu_iter_unit import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] acc_q, acc_d, opd_q, mpl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0] op_q;
  logic c_q, c_d;
  always_comb begin
    acc_d = op_q == F_SHL ? acc_q << 1 :
            op_q == F_SHR ? acc_q >> 1 :
            op_q == F_SAR ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} :
            mpl_q[0] ? acc_q + opd_q : acc_q;
    c_d = op_q == F_SHL ? acc_q[WIDTH-1] :
          (op_q == F_SHR || op_q == F_SAR) ? acc_q[0] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= F_NOP;
      acc_q <= '0;
      opd_q <= '0;
      mpl_q <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
    end else if (start_i) begin
      op_q  <= op_i;
      acc_q <= op_i == F_MUL ? '0 : a_i;
      opd_q <= a_i;
      mpl_q <= b_i;
      cnt_q <= op_i == F_MUL ? CNT_W'(WIDTH) : CNT_W'(b_i[SHAMT_W-1:0]);
      c_q   <= 1'b0;
    end else if (cnt_q != '0) begin
      acc_q <= acc_d;
      c_q   <= c_d;
      opd_q <= opd_q << 1;
      mpl_q <= mpl_q >> 1;
      cnt_q <= cnt_q - 1'b1;
    end
  end
  assign done_o = cnt_q == '0;
  assign res_o  = acc_q;
  assign c_o    = c_q;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake, registered result and persistent {s,z,c,v} flags
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       code
);
  localparam int SHAMT_W = $clog2(WIDTH);
  state_t state_q;
  logic pend_q, out_valid_q, accept, is_iter, iter_done, iter_c;
  logic c_d, v_d, wr_res, wr_code, cin, bin;
  logic [WIDTH-1:0] a_q, b_q, result_q, res_d, iter_res;
  logic [3:0] f_q, code_q;
  logic [WIDTH:0] sum, diff;
  assign in_ready = state_q == IDLE;
  assign accept   = in_valid && in_ready;
  assign is_iter  = fcode == F_MUL ||
                    ((fcode == F_SHL || fcode == F_SHR || fcode == F_SAR) && b[SHAMT_W-1:0] != '0);
  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && is_iter),
    .op_i    (fcode),
    .a_i     (a),
    .b_i     (b),
    .done_o  (iter_done),
    .res_o   (iter_res),
    .c_o     (iter_c)
  );
  // single-cycle ops evaluate one edge after accept, so they see flags written at their accept edge
  always_comb begin
    cin  = f_q == F_ADC && code_q[FC];
    bin  = f_q == F_SBC && code_q[FC];
    sum  = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin);
    diff = {1'b0, a_q} - {1'b0, b_q} - (WIDTH+1)'(bin);
    res_d   = a_q;
    c_d     = 1'b0;
    v_d     = 1'b0;
    wr_res  = 1'b1;
    wr_code = 1'b1;
    case (f_q)
      F_ADD, F_ADC: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = a_q[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != a_q[WIDTH-1];
      end
      F_SUB, F_SBC, F_CMP: begin
        res_d  = diff[WIDTH-1:0];
        c_d    = diff[WIDTH];
        v_d    = a_q[WIDTH-1] != b_q[WIDTH-1] && diff[WIDTH-1] != a_q[WIDTH-1];
        wr_res = f_q != F_CMP;
      end
      F_AND: res_d = a_q & b_q;
      F_OR:  res_d = a_q | b_q;
      F_XOR: res_d = a_q ^ b_q;
      F_MOV: res_d = b_q;
      F_SHL, F_SHR, F_SAR: res_d = a_q;
      default: begin
        wr_res  = 1'b0;
        wr_code = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      code_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= F_NOP;
    end else begin
      pend_q      <= accept && !is_iter;
      out_valid_q <= pend_q || (state_q == ITER && iter_done);
      if (accept) begin
        a_q <= a;
        b_q <= b;
        f_q <= fcode;
      end
      if (pend_q && wr_res) result_q <= res_d;
      if (pend_q && wr_code) code_q <= {res_d[WIDTH-1], res_d == '0, c_d, v_d};
      if (state_q == ITER && iter_done) begin
        result_q <= iter_res;
        code_q   <= {iter_res[WIDTH-1], iter_res == '0, iter_c, 1'b0};
      end
      state_q <= (state_q == IDLE && accept && is_iter) ? ITER :
                 (state_q == ITER && iter_done) ? IDLE : state_q;
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign code      = code_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with hand-computed results, flags and latencies for alu_mc (WIDTH=16)
module tb_alu_mc;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, out_valid;
  logic [15:0] a = '0, b = '0, result;
  logic [3:0] fcode = F_NOP, code;
  int n_tests = 0, n_fail = 0;
  int lat;
  bit busy, seen;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fcode     (fcode),
    .out_valid (out_valid),
    .result    (result),
    .code      (code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns #1 after the accept edge with inputs scrambled, so the DUT must use latched operands
  task automatic issue(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    fcode = f;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fcode = F_NOP;
    a = 16'hDEAD;
    b = 16'hBEEF;
  endtask

  task automatic wait_ov(output int l, output bit bz);
    l = 0;
    bz = !in_ready;
    do begin
      @(posedge clk);
      #1;
      l++;
      if (!out_valid && !in_ready) bz = 1'b1;
    end while (!out_valid && l < 40);
  endtask

  task automatic op(input string tag, input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                    input logic [15:0] er, input logic [3:0] ec, input int el);
    int l;
    bit bz;
    issue(f, x, y);
    wait_ov(l, bz);
    chk({tag, "/lat"}, l, el);
    chk({tag, "/result"}, result, er);
    chk({tag, "/code"}, code, ec);
    chk({tag, "/stall"}, bz, el > 1);
    @(posedge clk);
    #1;
    chk({tag, "/pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst/in_ready", in_ready, 1'b1);
    chk("rst/out_valid", out_valid, 1'b0);
    chk("rst/result", result, 16'h0000);
    chk("rst/code", code, 4'b0000);

    op("add_ovf", F_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1);
    op("sub_brw", F_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1);
    op("sbc",     F_SBC, 16'h0005, 16'h0002, 16'h0002, 4'b0000, 1);
    op("mov",     F_MOV, 16'h0000, 16'h1234, 16'h1234, 4'b0000, 1);
    op("cmp",     F_CMP, 16'h0003, 16'h0003, 16'h1234, 4'b0100, 1);
    op("nop",     F_NOP, 16'h0001, 16'h0002, 16'h1234, 4'b0100, 1);
    op("and",     F_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1);
    op("or",      F_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1);
    op("xor",     F_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1);
    op("sub_ovf", F_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1);
    op("sar4",    F_SAR, 16'h8000, 16'h0004, 16'hF800, 4'b1000, 5);
    op("shl1",    F_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2);
    op("shr1",    F_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 2);
    op("shl0",    F_SHL, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1);
    op("sar0",    F_SAR, 16'h8000, 16'h0010, 16'h8000, 4'b1000, 1);
    op("mul",     F_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 4'b1000, 17);

    // reset lands on the 8th edge after accepting a multiply
    issue(F_MUL, 16'h00FF, 16'h0101);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mulrst/no_out_valid", seen, 1'b0);
    chk("mulrst/result", result, 16'h0000);
    chk("mulrst/code", code, 4'b0000);
    chk("mulrst/in_ready", in_ready, 1'b1);

    // back-to-back: ADC consumes the carry written by the ADD one cycle earlier
    @(negedge clk);
    fcode = F_ADD;
    a = 16'hFFFF;
    b = 16'h0001;
    in_valid = 1'b1;
    @(negedge clk);
    fcode = F_ADC;
    a = 16'h0000;
    b = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_add/out_valid", out_valid, 1'b1);
    chk("b2b_add/result", result, 16'h0000);
    chk("b2b_add/code", code, 4'b0110);
    @(negedge clk);
    chk("b2b_adc/out_valid", out_valid, 1'b1);
    chk("b2b_adc/result", result, 16'h0001);
    chk("b2b_adc/code", code, 4'b0000);

    // requester holds an ADD through the multiply stall
    issue(F_MUL, 16'h00FF, 16'h0101);
    fcode = F_ADD;
    a = 16'h0001;
    b = 16'h0001;
    in_valid = 1'b1;
    wait_ov(lat, busy);
    chk("hold_mul/lat", lat, 17);
    chk("hold_mul/result", result, 16'hFFFF);
    chk("hold_mul/in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_ov(lat, busy);
    chk("hold_add/lat", lat, 1);
    chk("hold_add/result", result, 16'h0002);
    chk("hold_add/code", code, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
